// File: rtl/wb_ssram_bridge.sv
// rtl/wb_ssram_bridge.sv - Wishbone classic slave to pipelined SSRAM bridge; each 32-bit access becomes 32/DW SSRAM beats.
// Define WB_SSRAM_BEAT_SKIP_EN to skip write beats whose byte lanes are all deselected.
module wb_ssram_bridge #(
  parameter int          DW       = 16,
  parameter int          AW       = 19,
  parameter int          RD_LAT   = 2,
  parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     adr,
  input  logic [31:0]     din,
  output logic [31:0]     dout,
  input  logic            we,
  input  logic [3:0]      sel,
  input  logic            stb,
  input  logic            cyc,
  output logic            ack,
  output logic            err,
  output logic            rty,
  input  logic            SSRAM_CLK_IN,
  output logic            SSRAM_CLK,
  output logic [AW-1:0]   SSRAM_A,
  output logic            SSRAM_CE_N,
  output logic            SSRAM_WE_N,
  output logic            SSRAM_OE_N,
  output logic [DW/8-1:0] SSRAM_BW_N,
  input  logic [DW-1:0]   SSRAM_DQ_I,
  output logic [DW-1:0]   SSRAM_DQ_O,
  output logic [DW-1:0]   SSRAM_DQ_T
);
  localparam int NB  = 32 / DW;
  localparam int BPB = DW / 8;
  localparam int BSH = $clog2(BPB);
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int DSH = AW + BSH;

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_DRAIN, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wa_q, wa_d;
  logic [31:0]       din_q, din_d;
  logic [31:0]       dout_q, dout_d;
  logic [3:0]        sel_q, sel_d;
  logic [BCW-1:0]    beat_q, beat_d;
  logic [BCW-1:0]    cap_q, cap_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              req, hit, cap_fire;
  logic [NB-1:0]     en_new, en_cur;
  int                nxt;
  logic              unused_adr;

  function automatic logic [BPB-1:0] lanes(input logic [3:0] s, input int b);
    logic [3:0] t;
    t = s >> (b * BPB);
    return t[BPB-1:0];
  endfunction

  function automatic int next_beat(input logic [NB-1:0] e, input int from);
    int n;
    n = NB;
    for (int b = NB - 1; b >= 0; b--) begin
      if (b >= from && e[b]) n = b;
    end
    return n;
  endfunction

`ifdef WB_SSRAM_BEAT_SKIP_EN
  always_comb begin
    en_new = '0;
    en_cur = '0;
    for (int b = 0; b < NB; b++) begin
      en_new[b] = |lanes(sel, b);
      en_cur[b] = |lanes(sel_q, b);
    end
  end
`else
  assign en_new = '1;
  assign en_cur = '1;
`endif

  // Hold off new requests while ack/err is visible so a master still
  // presenting the finished request is not serviced twice.
  assign req        = cyc & stb & ~ack_q & ~err_q;
  assign hit        = (adr[31:DSH] == BASE_ADR[31:DSH]);
  assign cap_fire   = vld_q[RD_LAT-1];
  assign unused_adr = ^adr[1:0];

  always_comb begin
    state_d = state_q;
    wa_d    = wa_q;
    din_d   = din_q;
    sel_d   = sel_q;
    beat_d  = beat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    nxt     = 0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!hit) begin
            state_d = ERR;
          end else begin
            wa_d  = adr[DSH-1:BSH] & ~AW'(NB - 1);
            din_d = din;
            sel_d = sel;
            if (we) begin
              nxt = next_beat(en_new, 0);
              if (nxt == NB) begin
                state_d = DONE;
              end else begin
                state_d = WR;
                beat_d  = BCW'(nxt);
              end
            end else begin
              state_d = RD_ISSUE;
              beat_d  = '0;
            end
          end
        end
      end
      WR: begin
        nxt = next_beat(en_cur, int'(beat_q) + 1);
        if (nxt == NB) state_d = DONE;
        else beat_d = BCW'(nxt);
      end
      RD_ISSUE: begin
        if (beat_q == BCW'(NB - 1)) state_d = RD_DRAIN;
        else beat_d = beat_q + 1'b1;
      end
      RD_DRAIN: begin
        if (cap_fire && cap_q == BCW'(NB - 1)) state_d = DONE;
      end
      DONE: begin
        ack_d   = cyc & stb;
        state_d = IDLE;
      end
      ERR: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue history: bit RD_LAT-1 marks the clock at which the beat issued
  // RD_LAT clocks earlier is present on SSRAM_DQ_I.
  always_comb begin
    vld_d  = (vld_q << 1) | RD_LAT'(state_q == RD_ISSUE);
    cap_d  = cap_q;
    dout_d = dout_q;
    if (cap_fire) begin
      dout_d[int'(cap_q)*DW +: DW] = SSRAM_DQ_I;
      cap_d = cap_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wa_q    <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      sel_q   <= '0;
      beat_q  <= '0;
      cap_q   <= '0;
      vld_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wa_q    <= wa_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      sel_q   <= sel_d;
      beat_q  <= beat_d;
      cap_q   <= cap_d;
      vld_q   <= vld_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign SSRAM_CLK = SSRAM_CLK_IN;
  assign ack       = ack_q;
  assign err       = err_q;
  assign rty       = 1'b0;
  assign dout      = dout_q;

  always_comb begin
    SSRAM_A    = '0;
    SSRAM_CE_N = 1'b1;
    SSRAM_WE_N = 1'b1;
    SSRAM_OE_N = 1'b1;
    SSRAM_BW_N = '1;
    SSRAM_DQ_O = '0;
    SSRAM_DQ_T = '1;
    case (state_q)
      WR: begin
        SSRAM_A    = wa_q | AW'(beat_q);
        SSRAM_CE_N = 1'b0;
        SSRAM_WE_N = 1'b0;
        SSRAM_BW_N = ~lanes(sel_q, int'(beat_q));
        SSRAM_DQ_O = din_q[int'(beat_q)*DW +: DW];
        SSRAM_DQ_T = '0;
      end
      RD_ISSUE: begin
        SSRAM_A    = wa_q | AW'(beat_q);
        SSRAM_CE_N = 1'b0;
        SSRAM_OE_N = 1'b0;
      end
      default: ;
    endcase
  end
endmodule
